// File: rtl/mm_modexp_sched_pkg.sv
// Shared types for the modular-exponentiation sequencer:
// BRAM slot map, FSM state encoding and Montgomery op codes.
package mm_modexp_sched_pkg;

    typedef enum logic [2:0] {
        SLOT_BASE = 3'd0,
        SLOT_X    = 3'd1,
        SLOT_ACC  = 3'd2,
        SLOT_R2   = 3'd3,
        SLOT_ONE  = 3'd4,
        SLOT_Y    = 3'd5
    } slot_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } sched_state_t;

    typedef enum logic [2:0] {
        OP_TO_X,
        OP_TO_ACC,
        OP_SQ,
        OP_MUL,
        OP_FROM
    } mm_op_t;

    typedef struct packed {
        slot_t a;
        slot_t b;
        slot_t res;
    } slot_triple_t;

    // Operand/result routing for each Montgomery op.
    function automatic slot_triple_t op_slots(mm_op_t op);
        slot_triple_t t;
        t.a   = SLOT_BASE;
        t.b   = SLOT_R2;
        t.res = SLOT_X;
        unique case (op)
            OP_TO_X: begin
                t.a   = SLOT_BASE;
                t.b   = SLOT_R2;
                t.res = SLOT_X;
            end
            OP_TO_ACC: begin
                t.a   = SLOT_ONE;
                t.b   = SLOT_R2;
                t.res = SLOT_ACC;
            end
            OP_SQ: begin
                t.a   = SLOT_ACC;
                t.b   = SLOT_ACC;
                t.res = SLOT_ACC;
            end
            OP_MUL: begin
                t.a   = SLOT_ACC;
                t.b   = SLOT_X;
                t.res = SLOT_ACC;
            end
            OP_FROM: begin
                t.a   = SLOT_ACC;
                t.b   = SLOT_ONE;
                t.res = SLOT_Y;
            end
            default: begin
                t.a   = SLOT_BASE;
                t.b   = SLOT_R2;
                t.res = SLOT_X;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mm_modexp_sched_if.sv
// Start/done handshake and slot selects between the
// sequencer (master) and the Montgomery multiplier top (slave).
interface mm_modexp_sched_if;
    import mm_modexp_sched_pkg::*;

    logic  mm_start;
    slot_t mm_a_sel;
    slot_t mm_b_sel;
    slot_t mm_res_sel;
    logic  mm_done;

    modport master (
        output mm_start,
        output mm_a_sel,
        output mm_b_sel,
        output mm_res_sel,
        input  mm_done
    );

    modport slave (
        input  mm_start,
        input  mm_a_sel,
        input  mm_b_sel,
        input  mm_res_sel,
        output mm_done
    );

endinterface

// File: rtl/mm_modexp_sched_op_issuer.sv
// Single-op launcher: ISSUE pulse, WAIT for done, NEXT slot.
// Selects are registered at launch and held until the op retires.
module mm_op_issuer
    import mm_modexp_sched_pkg::*;
(
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         op_valid,
    input  slot_triple_t op_sel,
    output logic         op_done,
    mm_modexp_sched_if.master mm
);

    sched_state_t state_q;
    sched_state_t state_d;
    slot_triple_t sel_q;
    logic         start_q;
    logic         start_d;
    logic         load;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            sel_q.a   <= SLOT_BASE;
            sel_q.b   <= SLOT_BASE;
            sel_q.res <= SLOT_BASE;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            if (load) begin
                sel_q <= op_sel;
            end
        end
    end

    // A new op is only accepted while idle or in the NEXT slot.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        load    = 1'b0;
        op_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    load    = 1'b1;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mm.mm_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                op_done = 1'b1;
                if (op_valid) begin
                    load    = 1'b1;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mm.mm_start   = start_q;
    assign mm.mm_a_sel   = sel_q.a;
    assign mm.mm_b_sel   = sel_q.b;
    assign mm.mm_res_sel = sel_q.res;

endmodule

// File: rtl/mm_modexp_sched.sv
// Left-to-right square-and-multiply sequencer for Y = B^E mod P.
// Scans off leading exponent zeros, then routes Montgomery ops slot by slot.
module mm_modexp_sched
    import mm_modexp_sched_pkg::*;
#(
    parameter int E_BITS = 32,
    parameter int OPS_W  = $clog2(2 * E_BITS + 4)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [E_BITS-1:0] exp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [OPS_W-1:0]  mm_ops_o,
    mm_modexp_sched_if.master mm
);

    localparam int K_W = $clog2(E_BITS + 1);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [E_BITS-1:0] exp_q;
    logic [E_BITS-1:0] exp_d;
    logic [E_BITS-1:0] exp_shl;
    logic [K_W-1:0]    k_q;
    logic [K_W-1:0]    k_d;
    mm_op_t            op_q;
    mm_op_t            op_d;
    logic [OPS_W-1:0]  ops_q;
    logic [OPS_W-1:0]  ops_d;
    logic              op_valid;
    logic              op_done;
    slot_triple_t      op_sel;

    assign exp_shl = {exp_q[E_BITS-2:0], 1'b0};

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            k_q     <= '0;
            op_q    <= OP_TO_X;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            k_q     <= k_d;
            op_q    <= op_d;
            ops_q   <= ops_d;
        end
    end

    // ST_ISSUE here covers the whole op loop; the issuer
    // sequences ISSUE/WAIT/NEXT and flags NEXT via op_done.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        k_d      = k_q;
        op_d     = op_q;
        ops_d    = ops_q;
        op_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    exp_d = exp_i;
                    k_d   = K_W'(E_BITS);
                    ops_d = '0;
                    if (exp_i[E_BITS-1]) begin
                        op_valid = 1'b1;
                        op_d     = OP_TO_X;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                exp_d = exp_shl;
                k_d   = k_q - K_W'(1);
                if (exp_q[E_BITS-2] || k_q == K_W'(1)) begin
                    op_valid = 1'b1;
                    op_d     = OP_TO_X;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_done) begin
                    unique case (op_q)
                        OP_TO_X: begin
                            op_valid = 1'b1;
                            op_d     = OP_TO_ACC;
                        end
                        OP_TO_ACC: begin
                            op_valid = 1'b1;
                            if (k_q != '0) begin
                                op_d = OP_SQ;
                            end else begin
                                op_d = OP_FROM;
                            end
                        end
                        OP_SQ, OP_MUL: begin
                            op_valid = 1'b1;
                            if (op_q == OP_SQ && exp_q[E_BITS-1]) begin
                                op_d = OP_MUL;
                            end else begin
                                exp_d = exp_shl;
                                k_d   = k_q - K_W'(1);
                                if (k_q != K_W'(1)) begin
                                    op_d = OP_SQ;
                                end else begin
                                    op_d = OP_FROM;
                                end
                            end
                        end
                        OP_FROM: begin
                            state_d = ST_DONE;
                        end
                        default: begin
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (op_valid) begin
            ops_d = ops_d + OPS_W'(1);
        end
    end

    assign op_sel = op_slots(op_d);

    mm_op_issuer u_issuer (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .op_valid (op_valid),
        .op_sel   (op_sel),
        .op_done  (op_done),
        .mm       (mm)
    );

    assign busy_o   = (state_q == ST_SCAN) || (state_q == ST_ISSUE);
    assign done_o   = (state_q == ST_DONE);
    assign mm_ops_o = ops_q;

endmodule
